scr1_pipe_mprf_acc: RTL

Debug-side access sequencer for the multi-port register file (MPRF). It accepts single-register read/write commands from the debug module, and while the hart is halted it borrows the MPRF rs1 read port and the rd write port from the EXU. It returns a response with read data and error status. It sits between the EXU and the MPRF and is transparent to the EXU whenever no debug access is in progress.

---
 rtl/scr1_pipe_mprf_acc_pkg.sv | 26 ++
 rtl/scr1_pipe_mprf_acc.sv | 133 +++++++++++++
 2 files changed

// File: rtl/scr1_pipe_mprf_acc_pkg.sv
// Shared types for the debug-side MPRF access sequencer.
package scr1_pipe_mprf_acc_pkg;

   localparam int unsigned SCR1_MPRF_ADDR_WIDTH = 5;
   localparam int unsigned SCR1_XLEN            = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } type_scr1_mprf_acc_fsm_e;

   // Latched debug command at the default core geometry
   typedef struct packed {
      logic                            wr;
      logic [SCR1_MPRF_ADDR_WIDTH-1:0] addr;
      logic [SCR1_XLEN-1:0]            wdata;
   } type_scr1_mprf_acc_cmd_s;

   // In RV32E only x0..x15 exist
   function automatic logic scr1_acc_addr_illegal(input logic rve, input logic [31:0] addr);
      return rve & (addr[31:4] != 28'd0);
   endfunction

endpackage

// File: rtl/scr1_pipe_mprf_acc.sv
// Debug access sequencer: borrows the MPRF rs1 read port and rd write port from the EXU
// while the hart is halted to serve single-register debug reads and writes.
import scr1_pipe_mprf_acc_pkg::*;

module scr1_pipe_mprf_acc #(
   parameter int unsigned ADDR_W = SCR1_MPRF_ADDR_WIDTH,
   parameter int unsigned XLEN   = SCR1_XLEN,
   parameter bit          RVE    = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   // Debug module command / response
   input  logic              i_dm2acc_req,
   input  logic              i_dm2acc_wr,
   input  logic [ADDR_W-1:0] i_dm2acc_addr,
   input  logic [XLEN-1:0]   i_dm2acc_wdata,
   output logic              o_acc2dm_ack,
   output logic              o_acc2dm_resp_vld,
   input  logic              i_dm2acc_resp_rdy,
   output logic              o_acc2dm_resp_err,
   output logic [XLEN-1:0]   o_acc2dm_rdata,
   // Hart status
   input  logic              i_hdu2acc_halted,
   // EXU side
   input  logic [ADDR_W-1:0] i_exu2acc_rs1_addr,
   input  logic              i_exu2acc_w_req,
   input  logic [ADDR_W-1:0] i_exu2acc_rd_addr,
   input  logic [XLEN-1:0]   i_exu2acc_rd_data,
   output logic [XLEN-1:0]   o_acc2exu_rs1_data,
   // MPRF side
   output logic [ADDR_W-1:0] o_acc2mprf_rs1_addr,
   output logic              o_acc2mprf_w_req,
   output logic [ADDR_W-1:0] o_acc2mprf_rd_addr,
   output logic [XLEN-1:0]   o_acc2mprf_rd_data,
   input  logic [XLEN-1:0]   i_mprf2acc_rs1_data
);

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [XLEN-1:0]   wdata;
   } acc_cmd_t;

   type_scr1_mprf_acc_fsm_e r_state;
   acc_cmd_t                r_cmd;
   logic                    r_err;
   logic [XLEN-1:0]         r_rdata;

   logic                    w_accept;
   logic                    w_cmd_err;

   assign w_accept  = (r_state == IDLE) & i_dm2acc_req;
   // Halt and legality are only judged at accept time
   assign w_cmd_err = ~i_hdu2acc_halted | scr1_acc_addr_illegal(RVE, 32'(i_dm2acc_addr));

   // Sequencer FSM with latched command and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cmd   <= '0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (i_dm2acc_req) begin
                  r_cmd.wr    <= i_dm2acc_wr;
                  r_cmd.addr  <= i_dm2acc_addr;
                  r_cmd.wdata <= i_dm2acc_wdata;
                  r_rdata     <= '0;
                  if (w_cmd_err) begin
                     r_err   <= 1'b1;
                     r_state <= RESP;
                  end else begin
                     r_err   <= 1'b0;
                     r_state <= i_dm2acc_wr ? WRITE : READ;
                  end
               end
            end
            READ: begin
               // x0 reads as zero regardless of what the MPRF returns
               r_rdata <= (r_cmd.addr == '0) ? '0 : i_mprf2acc_rs1_data;
               r_err   <= 1'b0;
               r_state <= RESP;
            end
            WRITE: begin
               r_rdata <= '0;
               r_err   <= 1'b0;
               r_state <= RESP;
            end
            RESP: begin
               if (i_dm2acc_resp_rdy) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Port mux: EXU owns the MPRF except during the single READ/WRITE cycle
   always_comb begin
      o_acc2mprf_rs1_addr = i_exu2acc_rs1_addr;
      o_acc2mprf_w_req    = i_exu2acc_w_req;
      o_acc2mprf_rd_addr  = i_exu2acc_rd_addr;
      o_acc2mprf_rd_data  = i_exu2acc_rd_data;
      unique case (r_state)
         READ: begin
            o_acc2mprf_rs1_addr = r_cmd.addr;
            o_acc2mprf_w_req    = 1'b0;
         end
         WRITE: begin
            o_acc2mprf_w_req   = 1'b1;
            o_acc2mprf_rd_addr = r_cmd.addr;
            o_acc2mprf_rd_data = r_cmd.wdata;
         end
         IDLE, RESP: begin
         end
         default: begin
         end
      endcase
   end

   // Debug-side handshake outputs
   always_comb begin
      o_acc2dm_ack       = w_accept;
      o_acc2dm_resp_vld  = (r_state == RESP);
      o_acc2dm_resp_err  = r_err;
      o_acc2dm_rdata     = r_rdata;
      o_acc2exu_rs1_data = i_mprf2acc_rs1_data;
   end

endmodule
